// File: rtl/req_arbiter.sv
// req_arbiter: four-way round-robin request arbiter with sticky pending/timeout flags and a forced gap between grants.
module req_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       CP,
  input  logic       MR,
  input  logic [3:0] _REQ,
  input  logic       ACK,
  output logic [3:0] GNT,
  output logic       VALID,
  output logic [1:0] ID,
  output logic [3:0] PEND,
  output logic [3:0] ERR
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, ptr_nx, id_nx, pick, idx;
  logic [3:0] cnt, cnt_nx, gnt_nx, pend_nx, err_nx, clr;
  logic done;
  assign VALID = |GNT;
  always_comb begin
    pick = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      pick = PEND[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    id_nx = ID;
    cnt_nx = cnt;
    gnt_nx = GNT;
    err_nx = ERR;
    clr = '0;
    done = ACK || cnt == 4'(TIMEOUT - 1);
    case (state)
      IDLE: if (|PEND) begin
        state_nx = GRANT;
        id_nx = pick;
        gnt_nx = 4'b1 << pick;
        cnt_nx = '0;
      end
      GRANT: if (done) begin
        state_nx = GAP;
        gnt_nx = '0;
        id_nx = '0;
        ptr_nx = ID + 2'd1;
        cnt_nx = '0;
        clr = 4'b1 << ID;
        err_nx = ACK ? ERR : ERR | clr;
      end else cnt_nx = cnt + 4'd1;
      GAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a new request on the clearing edge keeps the flag set
    pend_nx = (PEND & ~clr) | ~_REQ;
  end
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= IDLE;
      GNT <= '0;
      ID <= '0;
      PEND <= '0;
      ERR <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      GNT <= gnt_nx;
      ID <= id_nx;
      PEND <= pend_nx;
      ERR <= err_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: scoreboard bench for req_arbiter built with TIMEOUT=3.
module tb_req_arbiter;
  localparam int TO = 3;
  logic CP = 0, MR = 1, ACK = 0;
  logic [3:0] _REQ = '1;
  logic [3:0] GNT, PEND, ERR;
  logic VALID;
  logic [1:0] ID;
  int checks = 0, errors = 0;
  int ms, mid, mptr, mcnt;
  logic [3:0] mp, me;
  logic [14:0] sb[$];
  int order[$];
  logic prev_valid;

  req_arbiter #(.TIMEOUT(TO)) dut (
    .CP(CP), .MR(MR), ._REQ(_REQ), .ACK(ACK),
    .GNT(GNT), .VALID(VALID), .ID(ID), .PEND(PEND), .ERR(ERR)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    ms = 0; mid = 0; mptr = 0; mcnt = 0; mp = '0; me = '0;
  endtask

  task automatic model(input logic [3:0] rn, input logic a);
    logic [3:0] c;
    c = '0;
    case (ms)
      0: if (mp != 0) begin
        for (int k = 0; k < 4; k++)
          if (mp[(mptr + k) % 4]) begin
            mid = (mptr + k) % 4;
            break;
          end
        ms = 1;
        mcnt = 0;
      end
      1: if (a || mcnt == TO - 1) begin
        c[mid] = 1'b1;
        if (!a) me[mid] = 1'b1;
        mptr = (mid + 1) % 4;
        ms = 2;
      end else mcnt++;
      default: ms = 0;
    endcase
    mp = (mp & ~c) | ~rn;
  endtask

  function automatic logic [14:0] expected();
    logic [3:0] g;
    g = (ms == 1) ? 4'(1 << mid) : 4'b0;
    return {g, mp, me, ms == 1, (ms == 1) ? 2'(mid) : 2'b0};
  endfunction

  task automatic step(input logic [3:0] rn, input logic a);
    logic [14:0] e;
    @(negedge CP);
    _REQ = rn;
    ACK = a;
    model(rn, a);
    sb.push_back(expected());
    @(posedge CP);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check("gnt", 16'(GNT), 16'(e[14:11]));
      check("pend", 16'(PEND), 16'(e[10:7]));
      check("err", 16'(ERR), 16'(e[6:3]));
      check("valid", 16'(VALID), 16'(e[2]));
      check("id", 16'(ID), 16'(e[1:0]));
    end
    if (VALID && !prev_valid) order.push_back(int'(ID));
    prev_valid = VALID;
  endtask

  task automatic do_reset;
    MR = 1;
    _REQ = '1;
    ACK = 0;
    @(negedge CP);
    @(negedge CP);
    MR = 0;
    model_reset();
    prev_valid = 0;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    model_reset();
    prev_valid = 0;
    #12;
    check("rst_gnt", 16'(GNT), 16'h0);
    check("rst_pend", 16'(PEND), 16'h0);
    check("rst_err", 16'(ERR), 16'h0);
    check("rst_valid", 16'(VALID), 16'h0);
    check("rst_id", 16'(ID), 16'h0);
    do_reset();
    // single request
    step(4'b1110, 0);
    step(4'b1111, 0);
    step(4'b1111, 1);
    step(4'b1111, 0);
    step(4'b1111, 0);
    // round robin with every grant acknowledged
    do_reset();
    order.delete();
    for (int i = 0; i < 16; i++) step(4'b0000, ms == 1);
    check("rr_count", 16'(order.size() >= 5), 16'd1);
    if (order.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 16'(order[i]), 16'(exp_order[i]));
    // set beats clear
    do_reset();
    step(4'b1011, 0);
    step(4'b1111, 0);
    step(4'b1011, 1);
    for (int i = 0; i < 4; i++) step(4'b1111, ms == 1);
    // timeout then err holds
    do_reset();
    step(4'b1101, 0);
    for (int i = 0; i < 8; i++) step(4'b1111, 0);
    // ack on the final grant cycle beats timeout
    do_reset();
    step(4'b0111, 0);
    for (int i = 0; i < 6; i++) step(4'b1111, ms == 1 && mcnt == TO - 1);
    // async reset mid-grant with err already set
    do_reset();
    step(4'b1101, 0);
    for (int i = 0; i < 6; i++) step(4'b1111, 0);
    step(4'b0111, 0);
    step(4'b1111, 0);
    check("pre_mr_gnt", 16'(GNT), 16'h8);
    #2;
    MR = 1;
    #1;
    check("mr_gnt", 16'(GNT), 16'h0);
    check("mr_pend", 16'(PEND), 16'h0);
    check("mr_err", 16'(ERR), 16'h0);
    check("mr_valid", 16'(VALID), 16'h0);
    @(negedge CP);
    MR = 0;
    model_reset();
    prev_valid = 0;
    step(4'b1111, 0);
    step(4'b1111, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
